// File: rtl/tpu_pkg.sv
// Shared opcodes, sequencer state encoding and size derivations for the TPU sequencer.
package tpu_pkg;

   localparam logic [2:0] OP_NOP     = 3'b000;
   localparam logic [2:0] OP_LOAD_A  = 3'b001;
   localparam logic [2:0] OP_LOAD_B  = 3'b010;
   localparam logic [2:0] OP_RUN     = 3'b011;
   localparam logic [2:0] OP_RUN_ACC = 3'b100;
   localparam logic [2:0] OP_READ    = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_COMPUTE = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   // A 1x1 array still needs a one-bit index field.
   function automatic int calc_idxw(input int n);
      return (n * n > 1) ? $clog2(n * n) : 1;
   endfunction

   function automatic int calc_cc(input int n);
      return 3 * n - 1;
   endfunction

   function automatic int calc_cw(input int n);
      return $clog2(calc_cc(n) + 1);
   endfunction

endpackage

// File: rtl/tpu_load_tracker.sv
// Tracks which A and B operand elements hold fresh data since the last pass start.
module tpu_load_tracker
   import tpu_pkg::*;
#(
   parameter  int N    = 2,
   localparam int IDXW = calc_idxw(N),
   localparam int NE   = N * N
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_en,
   input  logic            load_b,
   input  logic [IDXW-1:0] idx,
   input  logic            clear,
   output logic            all_loaded
);

   logic [NE-1:0] mask_a_q, mask_a_d;
   logic [NE-1:0] mask_b_q, mask_b_d;
   logic [NE-1:0] bit_sel;

   // Pass start wins over a same-cycle load so every pass demands a full reload.
   always_comb begin
      bit_sel  = NE'(1) << idx;
      mask_a_d = mask_a_q;
      mask_b_d = mask_b_q;
      if (clear) begin
         mask_a_d = '0;
         mask_b_d = '0;
      end else if (load_en) begin
         if (load_b) mask_b_d = mask_b_q | bit_sel;
         else        mask_a_d = mask_a_q | bit_sel;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_a_q <= '0;
         mask_b_q <= '0;
      end else begin
         mask_a_q <= mask_a_d;
         mask_b_q <= mask_b_d;
      end
   end

   assign all_loaded = (&mask_a_q) & (&mask_b_q);

endmodule

// File: rtl/tpu_seq_ctrl.sv
// Instruction sequencer for an N x N systolic MMU: operand loads, compute passes,
// result readout and abort.
module tpu_seq_ctrl
   import tpu_pkg::*;
#(
   parameter  int N        = 2,
   parameter  int AUTO_RUN = 1,
   localparam int IDXW     = calc_idxw(N),
   localparam int IW       = 3 + IDXW,
   localparam int CC       = calc_cc(N),
   localparam int CW       = calc_cw(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            instr_valid,
   input  logic [IW-1:0]   instr,
   output logic            instr_ready,
   input  logic            abort,
   output logic            mem_we,
   output logic            mem_sel_b,
   output logic [IDXW-1:0] mem_addr,
   output logic            mmu_en,
   output logic            mmu_clear,
   output logic [CW-1:0]   mmu_cycle,
   output logic            busy,
   output logic            done,
   output logic [IDXW-1:0] out_sel,
   output logic            out_valid,
   output logic            err
);

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              clr_q, clr_d;
   logic              we_q, we_d;
   logic              sel_q, sel_d;
   logic [IDXW-1:0]   addr_q, addr_d;
   logic [IDXW-1:0]   osel_q, osel_d;
   logic              ov_q, ov_d;
   logic              err_q, err_d;
   logic              accept, load_en, start, start_clear, all_loaded;
   logic [2:0]        op;
   logic [IDXW-1:0]   idx;

   assign op     = instr[2:0];
   assign idx    = instr[IW-1:3];
   assign accept = instr_valid && (state_q != ST_COMPUTE);

   tpu_load_tracker #(.N(N)) u_tracker (
      .clk        (clk),
      .rst        (rst),
      .load_en    (load_en),
      .load_b     (op[1]),
      .idx        (idx),
      .clear      (start),
      .all_loaded (all_loaded)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         clr_q   <= 1'b0;
         we_q    <= 1'b0;
         sel_q   <= 1'b0;
         addr_q  <= '0;
         osel_q  <= '0;
         ov_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         clr_q   <= clr_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         osel_q  <= osel_d;
         ov_q    <= ov_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = '0;
      clr_d       = 1'b0;
      we_d        = 1'b0;
      sel_d       = sel_q;
      addr_d      = addr_q;
      osel_d      = osel_q;
      ov_d        = 1'b0;
      err_d       = 1'b0;
      load_en     = 1'b0;
      start       = 1'b0;
      start_clear = 1'b0;
      if (state_q == ST_COMPUTE) begin
         // Abort outranks completion on the last step.
         if (abort)                         state_d = ST_IDLE;
         else if (cnt_q == CW'(CC - 1))     state_d = ST_DONE;
         else                               cnt_d   = cnt_q + CW'(1);
      end else begin
         if (accept) begin
            case (op)
               OP_NOP: ;
               OP_LOAD_A, OP_LOAD_B: begin
                  we_d    = 1'b1;
                  sel_d   = op[1];
                  addr_d  = idx;
                  load_en = 1'b1;
                  state_d = ST_LOAD;
               end
               OP_RUN, OP_RUN_ACC: begin
                  if (all_loaded) begin
                     start       = 1'b1;
                     start_clear = (op == OP_RUN);
                  end else begin
                     err_d = 1'b1;
                  end
               end
               OP_READ: begin
                  if (state_q == ST_DONE) begin
                     osel_d = idx;
                     ov_d   = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
               default: err_d = 1'b1;
            endcase
         end
         // Auto-start merges with any coincident RUN into a single clearing pass.
         if ((AUTO_RUN != 0) && all_loaded) begin
            start       = 1'b1;
            start_clear = 1'b1;
         end
         if (start) begin
            state_d = ST_COMPUTE;
            clr_d   = start_clear;
         end
      end
   end

   always_comb begin
      instr_ready = (state_q != ST_COMPUTE);
      mmu_en      = (state_q == ST_COMPUTE);
      busy        = (state_q == ST_COMPUTE);
      done        = (state_q == ST_DONE);
      mmu_cycle   = cnt_q;
      mmu_clear   = clr_q;
      mem_we      = we_q;
      mem_sel_b   = sel_q;
      mem_addr    = addr_q;
      out_sel     = osel_q;
      out_valid   = ov_q;
      err         = err_q;
   end

endmodule
